writeback_buffer: RTL and testbench
===================================

Name: writeback_buffer

Overview:
Small in-order FIFO between the execute/memory result path and the RegisterFile write port. It accepts (register, data) results, drains one per cycle into the RegisterFile's regWrite/writeReg/writeData inputs, and acts as the initiator of that write port. While results are pending, it forwards the newest pending value for two read addresses so the datapath never reads stale RegisterFile contents.

Parameters:
DEPTH, 4, number of pending entries (power of 2, >=2)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
wbValid  input  1  result offered this cycle
wbReg  input  ADDR_W  destination register of offered result
wbData  input  DATA_W  offered result value
wbReady  output  1  buffer can accept a result this cycle
drainEn  input  1  permit draining the head entry this cycle
regWrite  output  1  RegisterFile write enable
writeReg  output  ADDR_W  RegisterFile write address
writeData  output  DATA_W  RegisterFile write data
readReg1  input  ADDR_W  lookup address 1, same value driven to RegisterFile readReg1
readReg2  input  ADDR_W  lookup address 2
fwdHit1  output  1  readReg1 has a pending entry
fwdData1  output  DATA_W  newest pending value for readReg1
fwdHit2  output  1  readReg2 has a pending entry
fwdData2  output  DATA_W  newest pending value for readReg2
empty  output  1  no pending entries

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- State: circular storage of DEPTH entries {reg, data}; rdPtr, wrPtr, count (0..DEPTH).
- Reset: count=0, both pointers=0. After reset: wbReady=1, regWrite=0, writeReg=0, writeData=0, fwdHit1/2=0, fwdData1/2=0, empty=1.
- Accepting a result:
  - wbReady = (count < DEPTH).
  - A result is accepted when wbValid && wbReady.
  - An accepted result with wbReg==0 is consumed but not stored (x0 is never written).
  - No full-bypass: when full, wbReady=0 even if a pop occurs in the same cycle.
- Draining:
  - pop = drainEn && count>0 && !reset.
  - regWrite = pop. writeReg and writeData equal the head entry when count>0, else 0.
  - The RegisterFile captures the write on the same edge that pops the entry.
- Latency: a result accepted in cycle N is at the head no earlier than cycle N+1. The earliest RegisterFile write is at the edge ending cycle N+1.
- Simultaneous push and pop: count unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Ordering: strict FIFO. Two writes to the same register drain in acceptance order, so the last accepted value wins.
- Forwarding (combinational):
  - fwdHitK=1 iff readRegK!=0 and any stored entry (head included) has reg==readRegK.
  - fwdDataK is the data of the newest such entry, else 0.
  - The head entry being written this cycle still forwards, because RegisterFile contents update only at the edge.
  - A result offered in the same cycle (not yet stored) does not forward.
- drainEn=0: the head is held and regWrite=0. Accepts continue until full.
- Reset mid-operation: all pending entries are discarded. regWrite is forced 0 during the reset cycle so no partial write reaches the RegisterFile.
- empty = (count==0).

Decomposition:
- Shared package: REG_ADDR_W=5, DATA_W=32, ZERO_REG=5'd0, and the writeback entry struct/field widths {reg, data}. The RegisterFile and this block both use the package.
- One sub-module: wb_fwd_match. It performs the priority search (newest to oldest from wrPtr-1) of valid entries for a single address and returns {hit, data}. It is instantiated twice, for readReg1 and readReg2.

Test Plan:
- Reset then push {1, 32'hDEADBEEF} with drainEn=1 -> one cycle later regWrite=1, writeReg=1, writeData=DEADBEEF. After the next edge, empty=1, and the RegisterFile readData1 for readReg1=1 is DEADBEEF.
- drainEn=0, push {2, CAFEBABE} then {2, 12345678}, readReg1=2 -> fwdHit1=1, fwdData1=12345678. Then drainEn=1 -> two writes to reg 2 in order; the final RegisterFile value is 12345678.
- drainEn=0, push 4 entries -> wbReady=0. A fifth wbValid is not accepted and count stays 4. Drain all -> writes in order; the pointers wrap and a subsequent push/pop works correctly.
- Push {0, FFFFFFFF} -> accepted, empty stays 1, regWrite never asserted. readReg1=0 -> fwdHit1=0.
- Steady state with wbValid=1 and drainEn=1 every cycle (regs 3,4,5 with data 3,4,5) -> count stays at 1 and one regWrite per cycle, in order.
- Three entries pending, assert reset for one cycle -> regWrite=0 during reset. Afterwards empty=1, fwdHit1/2=0, and the RegisterFile is unchanged.

Source files
------------

// File: rtl/writeback_buffer_pkg.sv
// writeback_buffer_pkg: shared register-file widths and writeback entry layout
package writeback_buffer_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] regAddr;
    logic [DATA_W-1:0]     data;
  } wbEntry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: finds the newest valid pending entry whose register matches addr
// Ports: wrPtr (next write slot), valid (per-slot occupancy), regs/datas (slot contents),
//        addr (lookup register), hit/data (match flag and newest matching value, 0 if none)
module wb_fwd_match import writeback_buffer_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = writeback_buffer_pkg::DATA_W
) (
  input  logic [$clog2(DEPTH)-1:0]     wrPtr,
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] regs,
  input  logic [DEPTH-1:0][DATA_W-1:0] datas,
  input  logic [ADDR_W-1:0]            addr,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] idx;
  // Walk oldest to newest so the last overwrite is the newest match.
  always_comb begin
    hit = 1'b0;
    data = '0;
    idx = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      idx = wrPtr - PW'(i);
      if (addr != ADDR_W'(ZERO_REG) && valid[idx] && regs[idx] == addr) begin
        hit = 1'b1;
        data = datas[idx];
      end
    end
  end
endmodule

// File: rtl/writeback_buffer.sv
// writeback_buffer: in-order result FIFO draining into the RegisterFile write port with read forwarding
// Ports: clk/reset (sync active-high), wbValid/wbReg/wbData/wbReady (result intake),
//        drainEn (permit head write), regWrite/writeReg/writeData (RegisterFile write port),
//        readReg1/2 -> fwdHit1/2, fwdData1/2 (newest pending value), empty (nothing pending)
module writeback_buffer import writeback_buffer_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = writeback_buffer_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wbValid,
  input  logic [ADDR_W-1:0] wbReg,
  input  logic [DATA_W-1:0] wbData,
  output logic              wbReady,
  input  logic              drainEn,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic              fwdHit1,
  output logic [DATA_W-1:0] fwdData1,
  output logic              fwdHit2,
  output logic [DATA_W-1:0] fwdData2,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DEPTH-1:0][ADDR_W-1:0] regMem;
  logic [DEPTH-1:0][DATA_W-1:0] dataMem;
  logic [DEPTH-1:0]             validMask;
  logic [PW-1:0]                rdPtr, wrPtr;
  logic [CW-1:0]                count;
  logic                         push, pop;
  assign empty = count == '0;
  assign wbReady = count < CW'(DEPTH);
  // x0 results are accepted but never stored.
  assign push = wbValid && wbReady && wbReg != ADDR_W'(ZERO_REG);
  assign pop = drainEn && !empty && !reset;
  assign regWrite = pop;
  assign writeReg = empty ? '0 : regMem[rdPtr];
  assign writeData = empty ? '0 : dataMem[rdPtr];
  // A slot is live when its distance from the head is below count.
  for (genvar j = 0; j < DEPTH; j++) begin : g_valid
    assign validMask[j] = {1'b0, PW'(PW'(j) - rdPtr)} < count;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        regMem[wrPtr] <= wbReg;
        dataMem[wrPtr] <= wbData;
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) uMatch1 (
    .wrPtr(wrPtr), .valid(validMask), .regs(regMem), .datas(dataMem),
    .addr(readReg1), .hit(fwdHit1), .data(fwdData1)
  );
  wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) uMatch2 (
    .wrPtr(wrPtr), .valid(validMask), .regs(regMem), .datas(dataMem),
    .addr(readReg2), .hit(fwdHit2), .data(fwdData2)
  );
endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: directed checks of writeback_buffer against a simple RegisterFile model
module tb_writeback_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        wbValid;
  logic [4:0]  wbReg;
  logic [31:0] wbData;
  logic        wbReady;
  logic        drainEn;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1, readReg2;
  logic        fwdHit1, fwdHit2;
  logic [31:0] fwdData1, fwdData2;
  logic        empty;
  logic        rfClear;
  logic [31:0] rf [32];
  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  writeback_buffer dut (
    .clk(clk), .reset(reset), .wbValid(wbValid), .wbReg(wbReg), .wbData(wbData),
    .wbReady(wbReady), .drainEn(drainEn), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .fwdHit1(fwdHit1), .fwdData1(fwdData1), .fwdHit2(fwdHit2), .fwdData2(fwdData2),
    .empty(empty)
  );

  always @(posedge clk) begin
    if (rfClear) begin
      for (int k = 0; k < 32; k++) rf[k] <= '0;
    end else if (regWrite) begin
      rf[writeReg] <= writeData;
    end
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [4:0] r, input logic [31:0] d);
    wbValid = v;
    wbReg = r;
    wbData = d;
    #1;
  endtask

  initial begin
    reset = 1'b1; rfClear = 1'b1; drainEn = 1'b0; readReg1 = '0; readReg2 = '0;
    offer(1'b0, 5'd0, 32'd0);
    tick();
    reset = 1'b0; rfClear = 1'b0;
    #1;
    checkEq("rst_ready", wbReady, 1);
    checkEq("rst_regWrite", regWrite, 0);
    checkEq("rst_writeReg", writeReg, 0);
    checkEq("rst_writeData", writeData, 0);
    checkEq("rst_fwdHit1", fwdHit1, 0);
    checkEq("rst_fwdData1", fwdData1, 0);
    checkEq("rst_fwdHit2", fwdHit2, 0);
    checkEq("rst_empty", empty, 1);

    // single push drains one cycle later
    drainEn = 1'b1;
    offer(1'b1, 5'd1, 32'hDEADBEEF);
    checkEq("t1_noWriteYet", regWrite, 0);
    tick();
    offer(1'b0, 5'd0, 32'd0);
    checkEq("t1_regWrite", regWrite, 1);
    checkEq("t1_writeReg", writeReg, 1);
    checkEq("t1_writeData", writeData, 32'hDEADBEEF);
    checkEq("t1_notEmpty", empty, 0);
    tick();
    checkEq("t1_empty", empty, 1);
    checkEq("t1_rf1", rf[1], 32'hDEADBEEF);
    checkEq("t1_idle", regWrite, 0);

    // same-register forwarding, newest wins
    drainEn = 1'b0;
    readReg1 = 5'd2; readReg2 = 5'd1;
    offer(1'b1, 5'd2, 32'hCAFEBABE);
    checkEq("t2_offerNoFwd", fwdHit1, 0);
    tick();
    offer(1'b1, 5'd2, 32'h12345678);
    checkEq("t2_fwdOld", fwdData1, 32'hCAFEBABE);
    tick();
    offer(1'b0, 5'd0, 32'd0);
    checkEq("t2_fwdHit1", fwdHit1, 1);
    checkEq("t2_fwdData1", fwdData1, 32'h12345678);
    checkEq("t2_fwdHit2", fwdHit2, 0);
    checkEq("t2_held", regWrite, 0);
    drainEn = 1'b1;
    #1;
    checkEq("t2_w1", writeData, 32'hCAFEBABE);
    checkEq("t2_w1reg", writeReg, 2);
    tick();
    checkEq("t2_w2", writeData, 32'h12345678);
    checkEq("t2_headFwd", fwdData1, 32'h12345678);
    tick();
    checkEq("t2_empty", empty, 1);
    checkEq("t2_rf2", rf[2], 32'h12345678);
    checkEq("t2_noHit", fwdHit1, 0);

    // fill, reject while full, drain in order with wrap
    drainEn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 5'(8 + i), 32'(100 + i));
      tick();
    end
    offer(1'b1, 5'd12, 32'd999);
    checkEq("t3_full", wbReady, 0);
    tick();
    checkEq("t3_stillFull", wbReady, 0);
    drainEn = 1'b1;
    #1;
    checkEq("t3_noBypass", wbReady, 0);
    for (int i = 0; i < 4; i++) begin
      checkEq("t3_we", regWrite, 1);
      checkEq("t3_reg", writeReg, 5'(8 + i));
      checkEq("t3_data", writeData, 32'(100 + i));
      tick();
      offer(1'b0, 5'd0, 32'd0);
    end
    checkEq("t3_empty", empty, 1);
    checkEq("t3_rf11", rf[11], 32'd103);
    checkEq("t3_rf12", rf[12], 32'd0);
    offer(1'b1, 5'd13, 32'hABC);
    tick();
    offer(1'b0, 5'd0, 32'd0);
    checkEq("t3_wrapReg", writeReg, 13);
    checkEq("t3_wrapData", writeData, 32'hABC);
    tick();
    checkEq("t3_wrapEmpty", empty, 1);
    checkEq("t3_rf13", rf[13], 32'hABC);

    // x0 result consumed, never stored
    readReg1 = 5'd0;
    offer(1'b1, 5'd0, 32'hFFFFFFFF);
    checkEq("t4_ready", wbReady, 1);
    tick();
    offer(1'b0, 5'd0, 32'd0);
    checkEq("t4_empty", empty, 1);
    checkEq("t4_noWrite", regWrite, 0);
    checkEq("t4_noHit", fwdHit1, 0);

    // steady push+pop
    offer(1'b1, 5'd3, 32'd3);
    tick();
    for (int i = 4; i <= 6; i++) begin
      if (i <= 5) offer(1'b1, 5'(i), 32'(i)); else offer(1'b0, 5'd0, 32'd0);
      checkEq("t5_we", regWrite, 1);
      checkEq("t5_reg", writeReg, 5'(i - 1));
      checkEq("t5_data", writeData, 32'(i - 1));
      checkEq("t5_ready", wbReady, 1);
      tick();
    end
    offer(1'b0, 5'd0, 32'd0);
    checkEq("t5_empty", empty, 1);
    checkEq("t5_rf5", rf[5], 32'd5);

    // reset discards pending entries
    drainEn = 1'b0;
    readReg1 = 5'd6; readReg2 = 5'd7;
    offer(1'b1, 5'd6, 32'h66); tick();
    offer(1'b1, 5'd7, 32'h77); tick();
    offer(1'b1, 5'd9, 32'h99); tick();
    offer(1'b0, 5'd0, 32'd0);
    checkEq("t6_hit1", fwdHit1, 1);
    checkEq("t6_data2", fwdData2, 32'h77);
    reset = 1'b1; drainEn = 1'b1;
    #1;
    checkEq("t6_rstNoWrite", regWrite, 0);
    tick();
    reset = 1'b0; drainEn = 1'b0;
    #1;
    checkEq("t6_empty", empty, 1);
    checkEq("t6_hit1", fwdHit1, 0);
    checkEq("t6_hit2", fwdHit2, 0);
    checkEq("t6_rf6", rf[6], 32'd0);
    checkEq("t6_rf7", rf[7], 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
